// File: rtl/sync_mutex_rr_if.sv
// rtl/sync_mutex_rr_if.sv - request/grant bundle between requesters and the N-way mutex
interface sync_mutex_rr_if #(
  parameter int N    = 4,
  parameter int ID_W = 2
);

  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            busy;
  logic [ID_W-1:0] owner;
  logic            timeout;

  // Requester side: drives the level requests, observes ownership.
  modport master (
    output req,
    input  grant,
    input  busy,
    input  owner,
    input  timeout
  );

  // Arbiter side: samples requests, drives the registered ownership outputs.
  modport slave (
    input  req,
    output grant,
    output busy,
    output owner,
    output timeout
  );

endinterface

// File: rtl/sync_mutex_rr.sv
// rtl/sync_mutex_rr.sv - clocked N-way round-robin mutex; optional hold timeout via MUTEX_TIMEOUT_EN
module sync_mutex_rr #(
  parameter int N       = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 1024
) (
  input logic            clk_i,
  input logic            reset_i,
  sync_mutex_rr_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // Elaboration-time guard on the legal parameter space.
  if (N < 2 || N > 32 || ID_W != $clog2(N) || TIMEOUT < 2) begin : g_param_check
    $error("sync_mutex_rr: illegal parameter set");
  end

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_q,  last_d;
  logic            busy_q,  busy_d;

  logic [N-1:0]    req_eff;
  logic [N-1:0]    elig;
  logic            revoke;
  logic            keep;
  logic            new_grant;
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] cand;

  // Current owner keeps the grant while it requests, unless its hold is being revoked.
  assign keep = (state_q == ST_HELD) && bus.req[owner_q] && !revoke;

  // On a forced revoke the owner still requests, so it is removed from this round's candidates.
  assign elig = req_eff & ~(revoke ? grant_q : '0);

  // Round-robin scan starting just after the last winner; the last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = ID_W'((int'(last_q) + k) % N);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a grant hands over directly to a waiting core with no idle gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!keep) begin
          state_d = win_found ? ST_HELD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values: hold, hand over to the round-robin winner, or drop to idle.
  always_comb begin
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    busy_d    = busy_q;
    new_grant = 1'b0;
    if (!keep) begin
      if (win_found) begin
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
        owner_d          = win_idx;
        last_d           = win_idx;
        busy_d           = 1'b1;
        new_grant        = 1'b1;
      end else begin
        grant_d = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    end
  end

  // Registered outputs; the pointer restarts at N-1 so core 0 wins first after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= ID_W'(N - 1);
      busy_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

`ifdef MUTEX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             timeout_q;

  // Owner hit its hold limit while still requesting: take the grant away on the next edge.
  assign revoke  = (state_q == ST_HELD) && bus.req[owner_q] && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign req_eff = bus.req & ~mask_q;

  // Hold counter restarts on every new grant; a revoked core stays masked until its req drops.
  always_comb begin
    if (new_grant || !keep) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    mask_d = (mask_q & bus.req) | (revoke ? grant_q : '0);
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= revoke;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign revoke      = 1'b0;
  assign req_eff     = bus.req;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sync_mutex_rr.sv
// tb/tb_sync_mutex_rr.sv - directed self-checking bench for sync_mutex_rr (N=4, TIMEOUT=8)
module tb_sync_mutex_rr;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   n_onehot_err;
  int   n_busy_err;

  sync_mutex_rr_if #(.N(4), .ID_W(2)) bus_if();

  sync_mutex_rr #(.N(4), .ID_W(2), .TIMEOUT(8)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Invariants watched every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!$onehot0(bus_if.grant)) n_onehot_err++;
    if (bus_if.busy != (|bus_if.grant)) n_busy_err++;
    if (!bus_if.busy && bus_if.owner != 2'd0) n_busy_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus_if.req = 4'b0000;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    n_onehot_err = 0;
    n_busy_err   = 0;
    reset        = 1'b1;
    bus_if.req   = 4'b1111;

    // 1. reset held with all requests, then core 0 wins first
    step();
    check("t1_rst_grant0", 32'(bus_if.grant), 32'h0);
    check("t1_rst_busy0", 32'(bus_if.busy), 32'h0);
    step();
    check("t1_rst_grant1", 32'(bus_if.grant), 32'h0);
    check("t1_rst_owner", 32'(bus_if.owner), 32'h0);
    check("t1_rst_timeout", 32'(bus_if.timeout), 32'h0);
    reset = 1'b0;
    step();
    check("t1_first_grant", 32'(bus_if.grant), 32'h1);

    // 2. 1010 from idle -> core 1, then handover to 3 with no gap
    do_reset();
    bus_if.req = 4'b1010;
    step();
    check("t2_grant1", 32'(bus_if.grant), 32'h2);
    check("t2_owner1", 32'(bus_if.owner), 32'h1);
    bus_if.req = 4'b1000;
    step();
    check("t2_grant3", 32'(bus_if.grant), 32'h8);
    check("t2_owner3", 32'(bus_if.owner), 32'h3);
    check("t2_busy", 32'(bus_if.busy), 32'h1);
    bus_if.req = 4'b0000;
    step();
    check("t2_idle_grant", 32'(bus_if.grant), 32'h0);

    // 3. all request, each owner drops for one cycle after 3 -> order 0,1,2,3,0
    do_reset();
    bus_if.req = 4'b1111;
    step();
    check("t3_start_owner", 32'(bus_if.owner), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_hold_a", 32'(bus_if.grant), 32'(1 << i));
      step();
      check("t3_hold_b", 32'(bus_if.grant), 32'(1 << i));
      bus_if.req = 4'b1111 & ~4'(1 << i);
      step();
      check("t3_next_grant", 32'(bus_if.grant), 32'(1 << ((i + 1) % 4)));
      bus_if.req = 4'b1111;
    end
`ifndef MUTEX_TIMEOUT_EN
    check("t3_timeout_tied", 32'(bus_if.timeout), 32'h0);
`endif

    // 4. core 0 withdraws while 2 owns -> never granted, then idle
    do_reset();
    bus_if.req = 4'b0100;
    step();
    check("t4_owner2", 32'(bus_if.owner), 32'h2);
    bus_if.req = 4'b0101;
    step();
    check("t4_wait_a", 32'(bus_if.grant), 32'h4);
    step();
    check("t4_wait_b", 32'(bus_if.grant), 32'h4);
    bus_if.req = 4'b0100;
    step();
    check("t4_withdrawn", 32'(bus_if.grant), 32'h4);
    bus_if.req = 4'b0000;
    step();
    check("t4_idle_grant", 32'(bus_if.grant), 32'h0);
    check("t4_idle_busy", 32'(bus_if.busy), 32'h0);
    check("t4_idle_owner", 32'(bus_if.owner), 32'h0);

`ifdef MUTEX_TIMEOUT_EN
    // 5. core 0 never drops -> revoked after 8 held cycles, masked until it toggles
    do_reset();
    bus_if.req = 4'b0011;
    step();
    check("t5_grant0", 32'(bus_if.grant), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step();
      check("t5_hold", 32'(bus_if.grant), 32'h1);
      check("t5_no_pulse", 32'(bus_if.timeout), 32'h0);
    end
    step();
    check("t5_revoke_grant", 32'(bus_if.grant), 32'h2);
    check("t5_pulse", 32'(bus_if.timeout), 32'h1);
    step();
    check("t5_pulse_end", 32'(bus_if.timeout), 32'h0);
    bus_if.req = 4'b0001;
    step();
    check("t5_masked", 32'(bus_if.grant), 32'h0);
    bus_if.req = 4'b0000;
    step();
    bus_if.req = 4'b0001;
    step();
    check("t5_regrant", 32'(bus_if.grant), 32'h1);
`endif

    // 6. reset mid-hold drops the grant; pointer back to N-1
    do_reset();
    bus_if.req = 4'b0100;
    step();
    check("t6_held", 32'(bus_if.grant), 32'h4);
    reset = 1'b1;
    step();
    check("t6_rst_grant", 32'(bus_if.grant), 32'h0);
    check("t6_rst_busy", 32'(bus_if.busy), 32'h0);
    bus_if.req = 4'b0110;
    reset      = 1'b0;
    step();
    check("t6_after_rst", 32'(bus_if.grant), 32'h2);

    step();
    check("onehot0_grant", 32'(n_onehot_err), 32'h0);
    check("busy_owner_consistent", 32'(n_busy_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
